// File: rtl/grid_renderer_pkg.sv
// Shared codes for the snake game pixel path: entity and game-state encodings,
// 12-bit {R,G,B} palette, and a counter-width helper.
package grid_renderer_pkg;

    typedef enum logic [1:0] {
        ENTITY_NONE      = 2'd0,
        ENTITY_WALL      = 2'd1,
        ENTITY_OBJECTIVE = 2'd2,
        ENTITY_PLAYER    = 2'd3
    } entity_e;

    localparam logic [1:0] GAME_STATE_ALIVE = 2'd0;
    localparam logic [1:0] GAME_STATE_DEAD  = 2'd1;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_BG     = 12'h111;
    localparam logic [11:0] COLOR_WALL   = 12'h888;
    localparam logic [11:0] COLOR_OBJ    = 12'hF00;
    localparam logic [11:0] COLOR_PLAYER = 12'h0F0;
    localparam logic [11:0] COLOR_DEAD   = 12'hFF0;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/grid_renderer_pixel_delay_line.sv
// WIDTH x DEPTH shift register with a synchronous reset value.
// Ports: clk_25_2/rst (sync, active-high), din -> dout delayed by DEPTH cycles.
module grid_renderer_pixel_delay_line #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_25_2,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/grid_renderer.sv
// Pixel-side renderer for the snake game: turns VGA counters into cell queries,
// waits for the controller's entity code, and emits RGB with matched syncs.
// Also animates a blinking objective and a flashing dead snake, per frame.
// Ports: clk_25_2, rst (sync, active-high); h_cnt/v_cnt/video_on/hsync_in/
// vsync_in from the VGA timer; entity_data/game_state from the controller;
// cell_x/cell_y queries out; rgb, hsync_out, vsync_out to the DAC.
module grid_renderer
    import grid_renderer_pkg::*;
#(
    parameter int unsigned CELL_SHIFT     = 4,
    parameter int unsigned GRID_W         = 30,
    parameter int unsigned GRID_H         = 30,
    parameter int unsigned ENTITY_LATENCY = 5,
    parameter int unsigned BLINK_FRAMES   = 15,
    parameter int unsigned FLASH_FRAMES   = 8
) (
    input  logic        clk_25_2,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  entity_data,
    input  logic [1:0]  game_state,
    output logic [5:0]  cell_x,
    output logic [5:0]  cell_y,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int unsigned BLINK_W = cnt_width(BLINK_FRAMES);
    localparam int unsigned FLASH_W = cnt_width(FLASH_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);

    typedef struct packed {
        logic                  video_on;
        logic                  hsync;
        logic                  vsync;
        logic                  in_grid;
        logic [CELL_SHIFT-1:0] off_x;
        logic [CELL_SHIFT-1:0] off_y;
    } pix_t;

    localparam int unsigned PIX_W = $bits(pix_t);
    localparam pix_t PIX_IDLE = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                  in_grid: 1'b0, off_x: '0, off_y: '0};

    logic [5:0]         cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    pix_t               pix_s0_q, pix_s0_d;
    pix_t               pix_dly;
    logic [11:0]        rgb_q, rgb_d;
    logic               hsync_q, vsync_q;
    logic               vsync_prev_q;
    logic [1:0]         gs_prev_q;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               flash_phase_q, flash_phase_d;
    logic               frame_tick_c;

    // Stage 0: cell query and in-cell offsets; grid test on the untruncated cell index.
    always_comb begin
        cell_x_d         = 6'(h_cnt >> CELL_SHIFT);
        cell_y_d         = 6'(v_cnt >> CELL_SHIFT);
        pix_s0_d.video_on = video_on;
        pix_s0_d.hsync    = hsync_in;
        pix_s0_d.vsync    = vsync_in;
        pix_s0_d.in_grid  = (32'(h_cnt >> CELL_SHIFT) < GRID_W) &&
                            (32'(v_cnt >> CELL_SHIFT) < GRID_H);
        pix_s0_d.off_x    = h_cnt[CELL_SHIFT-1:0];
        pix_s0_d.off_y    = v_cnt[CELL_SHIFT-1:0];
    end

    // Hold position/sync bundle until the controller's answer arrives.
    grid_renderer_pixel_delay_line #(
        .WIDTH   (PIX_W),
        .DEPTH   (ENTITY_LATENCY),
        .RST_VAL (PIX_IDLE)
    ) u_delay (
        .clk_25_2 (clk_25_2),
        .rst      (rst),
        .din      (pix_s0_q),
        .dout     (pix_dly)
    );

    // Frame animation counters; a game-state change overrides a coincident tick.
    always_comb begin
        frame_tick_c  = vsync_prev_q & ~vsync_in;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;

        if (frame_tick_c) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        if (game_state != GAME_STATE_DEAD) begin
            flash_cnt_d   = '0;
            flash_phase_d = 1'b1;
        end else if (game_state != gs_prev_q) begin
            flash_cnt_d = '0;
        end else if (frame_tick_c) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FLASH_W'(1);
            end
        end
    end

    // Colour selection for the delayed pixel.
    always_comb begin
        rgb_d = COLOR_BLACK;
        if (pix_dly.video_on && pix_dly.in_grid) begin
            case (entity_data)
                ENTITY_NONE:      rgb_d = COLOR_BG;
                ENTITY_WALL:      rgb_d = COLOR_WALL;
                ENTITY_OBJECTIVE: rgb_d = blink_phase_q ? COLOR_OBJ : COLOR_BG;
                default: begin
                    // Top row and left column of each body cell form the segment gap.
                    if (pix_dly.off_x == '0 || pix_dly.off_y == '0) begin
                        rgb_d = COLOR_BG;
                    end else if (game_state == GAME_STATE_DEAD) begin
                        rgb_d = flash_phase_q ? COLOR_DEAD : COLOR_BG;
                    end else begin
                        rgb_d = COLOR_PLAYER;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            cell_x_q      <= '0;
            cell_y_q      <= '0;
            pix_s0_q      <= PIX_IDLE;
            rgb_q         <= COLOR_BLACK;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vsync_prev_q  <= 1'b1;
            gs_prev_q     <= GAME_STATE_ALIVE;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
        end else begin
            cell_x_q      <= cell_x_d;
            cell_y_q      <= cell_y_d;
            pix_s0_q      <= pix_s0_d;
            rgb_q         <= rgb_d;
            hsync_q       <= pix_dly.hsync;
            vsync_q       <= pix_dly.vsync;
            vsync_prev_q  <= vsync_in;
            gs_prev_q     <= game_state;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    assign cell_x    = cell_x_q;
    assign cell_y    = cell_y_q;
    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Randomised scoreboard bench for grid_renderer. A whole stimulus run is
// generated up front, the reference model derives every expected pixel from it,
// the driver pushes expectations as it issues each cycle, and a negedge
// monitor pops and compares them at the pipeline latency.
module tb_grid_renderer;
    import grid_renderer_pkg::*;

    localparam int N    = 3000;
    localparam int LAT  = 7;
    localparam int BF   = 3;
    localparam int FF   = 2;
    localparam int DEAD = 1;

    logic        clk_25_2 = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        video_on, hsync_in, vsync_in;
    logic [1:0]  entity_data, game_state;
    logic [5:0]  cell_x, cell_y;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    grid_renderer #(
        .CELL_SHIFT(4), .GRID_W(30), .GRID_H(30), .ENTITY_LATENCY(5),
        .BLINK_FRAMES(BF), .FLASH_FRAMES(FF)
    ) dut (
        .clk_25_2(clk_25_2), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .entity_data(entity_data), .game_state(game_state),
        .cell_x(cell_x), .cell_y(cell_y), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk_25_2 = ~clk_25_2;

    int h_a [N], v_a [N], g_a [N], e_a [N];
    bit vid_a [N], hs_a [N], vs_a [N], rst_a [N];
    bit bph [N], fph [N];

    typedef struct packed { int pix; logic [11:0] rgb; logic hs; logic vs; } pix_exp_t;
    typedef struct packed { int pix; logic [5:0] cx; logic [5:0] cy; } cell_exp_t;
    pix_exp_t  pix_q [$];
    cell_exp_t cell_q [$];

    int errors = 0;
    int checks = 0;

    task automatic gen_stimulus();
        int gcur = 0;
        for (int c = 0; c < N; c++) begin
            rst_a[c] = (c < 3) || (c >= 1500 && c < 1503);
            h_a[c]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023))
                                                    : int'($urandom_range(0, 639));
            v_a[c]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 1023))
                                                    : int'($urandom_range(0, 479));
            vid_a[c] = ($urandom_range(0, 4) != 0);
            hs_a[c]  = ($urandom_range(0, 15) != 0);
            vs_a[c]  = ($urandom_range(0, 11) != 0);
            if (c > 0 && c % 48 == 0)
                gcur = ($urandom_range(0, 1) == 1) ? DEAD : int'($urandom_range(0, 3));
            g_a[c] = gcur;
            e_a[c] = int'($urandom_range(0, 3));
        end
        // Directed pixels right after the initial reset.
        h_a[3] = 37;  v_a[3] = 50;  vid_a[3] = 1; e_a[3] = int'(ENTITY_WALL);
        h_a[4] = 32;  v_a[4] = 50;  vid_a[4] = 1; e_a[4] = int'(ENTITY_PLAYER);
        h_a[5] = 33;  v_a[5] = 49;  vid_a[5] = 1; e_a[5] = int'(ENTITY_PLAYER);
        h_a[6] = 480; v_a[6] = 100; vid_a[6] = 1; e_a[6] = int'(ENTITY_WALL);
        h_a[7] = 100; v_a[7] = 200; vid_a[7] = 0; e_a[7] = int'(ENTITY_WALL);
        h_a[8] = 100; v_a[8] = 479; vid_a[8] = 1; e_a[8] = int'(ENTITY_WALL);
        h_a[9] = 0;   v_a[9] = 5;   vid_a[9] = 1; e_a[9] = int'(ENTITY_PLAYER);
        // Tick coinciding with leaving DEAD.
        g_a[799] = DEAD; g_a[800] = 0; vs_a[799] = 1; vs_a[800] = 0;
        // Tick coinciding with entering DEAD, then a long dead stretch.
        g_a[1199] = 0; vs_a[1199] = 1; vs_a[1200] = 0;
        for (int c = 1200; c < 1290; c++) g_a[c] = DEAD;
        // Falling vsync while reset is held.
        vs_a[1500] = 1; vs_a[1501] = 0;
    endtask

    // Frame-animation phases seen during each cycle, from counted vsync falls.
    task automatic run_model();
        int bcnt = 0, fcnt = 0, pg = 0;
        bit pvs = 1, b = 1, f = 1, tick;
        for (int c = 0; c < N; c++) begin
            bph[c] = b;
            fph[c] = f;
            if (rst_a[c]) begin
                bcnt = 0; fcnt = 0; pg = 0; pvs = 1; b = 1; f = 1;
            end else begin
                tick = pvs && !vs_a[c];
                if (tick) begin
                    bcnt++;
                    if (bcnt == BF) begin bcnt = 0; b = !b; end
                end
                if (g_a[c] != DEAD) begin
                    fcnt = 0; f = 1;
                end else if (g_a[c] != pg) begin
                    fcnt = 0;
                end else if (tick) begin
                    fcnt++;
                    if (fcnt == FF) begin fcnt = 0; f = !f; end
                end
                pvs = vs_a[c];
                pg  = g_a[c];
            end
        end
    endtask

    function automatic pix_exp_t expect_pix(int i);
        pix_exp_t r;
        bit idle = 0;
        int k = i + LAT - 1;
        r.pix = i;
        for (int c = i; c <= k; c++) if (rst_a[c]) idle = 1;
        if (idle) begin
            r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
            return r;
        end
        r.hs = hs_a[i];
        r.vs = vs_a[i];
        if (!vid_a[i] || h_a[i] / 16 >= 30 || v_a[i] / 16 >= 30)
            r.rgb = 12'h000;
        else if (e_a[i] == int'(ENTITY_NONE))
            r.rgb = 12'h111;
        else if (e_a[i] == int'(ENTITY_WALL))
            r.rgb = 12'h888;
        else if (e_a[i] == int'(ENTITY_OBJECTIVE))
            r.rgb = bph[k] ? 12'hF00 : 12'h111;
        else if (h_a[i] % 16 == 0 || v_a[i] % 16 == 0)
            r.rgb = 12'h111;
        else if (g_a[k] == DEAD)
            r.rgb = fph[k] ? 12'hFF0 : 12'h111;
        else
            r.rgb = 12'h0F0;
        return r;
    endfunction

    task automatic drive(int i);
        cell_exp_t ce;
        rst         = rst_a[i];
        h_cnt       = 10'(h_a[i]);
        v_cnt       = 10'(v_a[i]);
        video_on    = vid_a[i];
        hsync_in    = hs_a[i];
        vsync_in    = vs_a[i];
        game_state  = 2'(g_a[i]);
        entity_data = (i >= LAT - 1) ? 2'(e_a[i-LAT+1]) : 2'(0);
        ce.pix = i;
        ce.cx  = rst_a[i] ? 6'd0 : 6'((h_a[i] / 16) % 64);
        ce.cy  = rst_a[i] ? 6'd0 : 6'((v_a[i] / 16) % 64);
        cell_q.push_back(ce);
        if (i + LAT - 1 < N) pix_q.push_back(expect_pix(i));
    endtask

    initial begin
        pix_exp_t idle_e;
        gen_stimulus();
        run_model();
        for (int p = -(LAT - 1); p < 0; p++) begin
            idle_e.pix = p; idle_e.rgb = 12'h000; idle_e.hs = 1'b1; idle_e.vs = 1'b1;
            pix_q.push_back(idle_e);
        end
        drive(0);
        for (int i = 1; i < N; i++) begin
            @(posedge clk_25_2);
            #1;
            drive(i);
        end
        repeat (3) @(posedge clk_25_2);
        #1;
        checks++;
        if (pix_q.size() != 0 || cell_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pixel queue=%0d cell queue=%0d, required 0 and 0",
                     pix_q.size(), cell_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: outputs after edge k belong to pixel k-1 (cells) and k-LAT (rgb/syncs).
    initial begin
        int k = 0;
        pix_exp_t  pe;
        cell_exp_t ce;
        forever begin
            @(negedge clk_25_2);
            k++;
            if (cell_q.size() > 0 && cell_q[0].pix + 1 == k) begin
                ce = cell_q.pop_front();
                checks++;
                if (cell_x !== ce.cx || cell_y !== ce.cy) begin
                    errors++;
                    $display("FAIL cell pix=%0d: got x=%0d y=%0d, required x=%0d y=%0d",
                             ce.pix, cell_x, cell_y, ce.cx, ce.cy);
                end
            end
            if (pix_q.size() > 0 && pix_q[0].pix + LAT == k) begin
                pe = pix_q.pop_front();
                checks++;
                if (rgb !== pe.rgb) begin
                    errors++;
                    $display("FAIL rgb pix=%0d: got %h, required %h", pe.pix, rgb, pe.rgb);
                end
                checks++;
                if (hsync_out !== pe.hs || vsync_out !== pe.vs) begin
                    errors++;
                    $display("FAIL sync pix=%0d: got hs=%b vs=%b, required hs=%b vs=%b",
                             pe.pix, hsync_out, vsync_out, pe.hs, pe.vs);
                end
            end
        end
    end

endmodule
